serial_stream_arbiter: RTL and testbench
========================================

# serial_stream_arbiter

Shares one `SerialToParallelStream` deserializer between `NUM_SOURCES` serial requesters. It grants the deserializer input to one source at a time and holds that grant for exactly one output word. It tags each completed parallel word with the id of the source that produced it. It sits between the serial front-ends and the shared deserializer, and wraps both sides of that deserializer.

## Interface
- `NUM_SOURCES`, default 4: number of serial requesters, ≥2.
- `INPUT_SIZE`, default 1: serial beat width; must match the deserializer.
- `OUTPUT_SIZE`, default 8: parallel word width; must be divisible by `INPUT_SIZE`.
- `clk` input 1: the single clock.
- `rstn` input 1: asynchronous, active-low reset.
- `src_valid` input `NUM_SOURCES`: per-source beat valid.
- `src_ready` output `NUM_SOURCES`: per-source beat ready; at most one bit is high at a time.
- `src_data` input `NUM_SOURCES*INPUT_SIZE`: packed beats; source i occupies bits `[i*INPUT_SIZE +: INPUT_SIZE]`.
- `s2p_in_valid` output 1: beat to the deserializer serial input.
- `s2p_in_ready` input 1: deserializer serial ready.
- `s2p_in_data` output `INPUT_SIZE`: beat to the deserializer.
- `s2p_out_valid` input 1: deserializer word valid.
- `s2p_out_ready` output 1: deserializer word ready.
- `s2p_out_data` input `OUTPUT_SIZE`: deserializer word.
- `out_valid` output 1: tagged word valid.
- `out_ready` input 1: downstream ready.
- `out_data` output `OUTPUT_SIZE`: tagged word, equal to `s2p_out_data`.
- `out_id` output `ID_W`: source id of `out_data`, where `ID_W = max(1, $clog2(NUM_SOURCES))`.

## Operation
- Every word contains `BEATS = OUTPUT_SIZE/INPUT_SIZE` beats. A word never interleaves beats from different sources.
- The FSM has two states, IDLE and BURST.
- IDLE: if any `src_valid` is high, pick the first valid source in round-robin order. The search starts at `last_grant+1` and wraps modulo `NUM_SOURCES`. Register the pick as `grant`, clear `beat_cnt`, and go to BURST. If no source is valid, stay in IDLE. In IDLE, all `src_ready` bits are low and `s2p_in_valid` is 0.
- BURST behaviour:
  - `s2p_in_valid = src_valid[grant]`
  - `s2p_in_data = src_data[grant]`
  - `src_ready[grant] = s2p_in_ready`
  - all other `src_ready` bits are 0
  - every accepted beat (`s2p_in_valid && s2p_in_ready`) increments `beat_cnt`
- On the accepted beat where `beat_cnt == BEATS-1`:
  - load `word_id <= grant` and `last_grant <= grant`
  - return to IDLE
- `beat_cnt` is `$clog2(BEATS)+1` bits wide and never exceeds `BEATS-1`.
- The granted source may deassert `src_valid` mid-word. The grant is held; there is no timeout and no preemption.
- The output side is a combinational pass-through:
  - `out_valid = s2p_out_valid`
  - `out_data = s2p_out_data`
  - `s2p_out_ready = out_ready`
  - `out_id = word_id`
- A single `word_id` register is sufficient. The deserializer cannot complete word k+1 while word k is still valid. When `BEATS == 1`, word k's consume and word k+1's last beat can share a cycle; `word_id` updates at that edge, after word k has been consumed.

## Timing
- Reset values: FSM = IDLE, `grant` = 0, `last_grant = NUM_SOURCES-1` (so source 0 wins first), `beat_cnt` = 0, `word_id` = 0.
- Outputs during reset: `src_ready` = 0, `s2p_in_valid` = 0, `out_id` = 0. `out_valid` and `s2p_out_ready` follow their inputs.
- Arbitration costs one bubble cycle per word. A request seen in IDLE at cycle t can first forward a beat at cycle t+1.
- Throughput with a continuously ready deserializer and continuous valid: `BEATS` beats per `BEATS+1` cycles.
- If several requesters are valid in the same IDLE cycle, only the round-robin winner is granted. The others keep waiting with `src_ready` = 0.
- The round-robin pointer advances only on word completion, not on grant.
- Reset asserted mid-word: everything returns to reset values asynchronously, and the partial word is discarded. The deserializer shares `rstn`, so its buffer is also cleared. Sources must re-send from a word boundary.

## Structure
- Package `serial_arb_pkg`:
  - `state_t` enum (IDLE, BURST)
  - helper function `rr_pick(valid, last)` returning the next index
- Sub-module `round_robin_picker`:
  - parameter `N`
  - inputs: `req[N]`, `last[ID_W]`
  - outputs: `any`, `pick[ID_W]`
  - purely combinational; reusable by later arbiters
- The deserializer itself is not instantiated here. The top level wires the arbiter to it.

## Test plan
- Single source 2 streams bytes 0xA5, 0x3C (`INPUT_SIZE=1`, `OUTPUT_SIZE=8`, deserializer always ready) -> `out_data` = 0xA5 then 0x3C, each with `out_id` = 2, one bubble cycle between words.
- All 4 sources valid continuously -> completed words carry `out_id` 0,1,2,3,0,… and no word mixes sources.
- Source 1 drops `src_valid` for 3 cycles after beat 4 while source 0 is valid -> grant stays on 1, `src_ready[0]` stays 0, and the word completes as source 1's byte with `out_id` = 1.
- `out_ready` held low after the first word -> `s2p_in_ready` falls, `src_ready[grant]` = 0, and `out_id` stays stable until consumed. The next word then completes normally.
- `BEATS=1` (`INPUT_SIZE=OUTPUT_SIZE=8`) with simultaneous consume and last beat -> each word has the correct `out_id` and no word is lost or duplicated.
- `rstn` pulsed low after 5 beats from source 3 -> IDLE, all ready bits 0. The next word is granted to source 0 if valid, and no partial data appears on `out_data`.

Source files
------------

// File: rtl/serial_arb_pkg.sv
// rtl/serial_arb_pkg.sv - shared state type and round-robin helper for the serial stream arbiter
package serial_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam int MAX_REQ = 32;

   // First set bit of valid strictly after last, wrapping at n; returns last when nothing is set.
   function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int last, input int n);
      int idx;
      int res;
      res = last;
      for (int k = MAX_REQ; k >= 1; k--) begin
         if (k <= n) begin
            idx = last + k;
            if (idx >= n) idx = idx - n;
            if (valid[idx[4:0]]) res = idx;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/round_robin_picker.sv
// rtl/round_robin_picker.sv - combinational round-robin request picker
module round_robin_picker
   import serial_arb_pkg::*;
#(
   parameter int  N    = 4,
   localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic            any,
   output logic [ID_W-1:0] pick
);

   logic [MAX_REQ-1:0] req_ext;

   assign req_ext = MAX_REQ'(req);
   assign any     = |req;
   assign pick    = ID_W'(rr_pick(req_ext, int'(last), N));

endmodule

// File: rtl/serial_stream_arbiter.sv
// rtl/serial_stream_arbiter.sv - word-granular round-robin sharing of one serial-to-parallel deserializer
module serial_stream_arbiter
   import serial_arb_pkg::*;
#(
   parameter int  NUM_SOURCES = 4,
   parameter int  INPUT_SIZE  = 1,
   parameter int  OUTPUT_SIZE = 8,
   localparam int ID_W        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [NUM_SOURCES-1:0]            src_valid,
   output logic [NUM_SOURCES-1:0]            src_ready,
   input  logic [NUM_SOURCES*INPUT_SIZE-1:0] src_data,
   output logic                              s2p_in_valid,
   input  logic                              s2p_in_ready,
   output logic [INPUT_SIZE-1:0]             s2p_in_data,
   input  logic                              s2p_out_valid,
   output logic                              s2p_out_ready,
   input  logic [OUTPUT_SIZE-1:0]            s2p_out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [OUTPUT_SIZE-1:0]            out_data,
   output logic [ID_W-1:0]                   out_id
);

   localparam int                BEATS      = OUTPUT_SIZE / INPUT_SIZE;
   localparam int                CNT_W      = $clog2(BEATS) + 1;
   localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BEATS - 1);
   localparam logic [ID_W-1:0]   RESET_LAST = ID_W'(NUM_SOURCES - 1);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [ID_W-1:0]   word_id_q, word_id_d;
   logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic              pick_any;
   logic [ID_W-1:0]   pick_idx;

   round_robin_picker #(.N(NUM_SOURCES)) u_picker (
      .req  (src_valid),
      .last (last_grant_q),
      .any  (pick_any),
      .pick (pick_idx)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= RESET_LAST;
         word_id_q    <= '0;
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         word_id_q    <= word_id_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      word_id_d    = word_id_q;
      beat_cnt_d   = beat_cnt_q;
      src_ready    = '0;
      s2p_in_valid = 1'b0;
      s2p_in_data  = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            s2p_in_valid       = src_valid[grant_q];
            s2p_in_data        = src_data[grant_q*INPUT_SIZE +: INPUT_SIZE];
            src_ready[grant_q] = s2p_in_ready;
            // The grant is held until the whole word is accepted, even across valid gaps.
            if (src_valid[grant_q] && s2p_in_ready) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  word_id_d    = grant_q;
                  last_grant_d = grant_q;
                  beat_cnt_d   = '0;
                  state_d      = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   assign out_valid     = s2p_out_valid;
   assign out_data      = s2p_out_data;
   assign s2p_out_ready = out_ready;
   assign out_id        = word_id_q;

endmodule

// File: tb/tb_serial_stream_arbiter.sv
// tb/tb_serial_stream_arbiter.sv - scoreboard bench for serial_stream_arbiter in bit-serial and byte-wide configurations
module tb_serial_stream_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bit-serial instance: 4 sources, 1-bit beats, 8-bit words
   logic [3:0] src_valid, src_ready, src_data;
   logic       s2p_in_valid, s2p_in_ready, s2p_out_valid, s2p_out_ready;
   logic       out_valid, out_ready;
   logic [0:0] s2p_in_data;
   logic [7:0] s2p_out_data, out_data;
   logic [1:0] out_id;

   serial_stream_arbiter #(.NUM_SOURCES(4), .INPUT_SIZE(1), .OUTPUT_SIZE(8)) dut (
      .clk(clk), .rstn(rstn),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .s2p_in_valid(s2p_in_valid), .s2p_in_ready(s2p_in_ready), .s2p_in_data(s2p_in_data),
      .s2p_out_valid(s2p_out_valid), .s2p_out_ready(s2p_out_ready), .s2p_out_data(s2p_out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
   );

   // Byte-wide instance: one beat per word
   logic [3:0]  b_src_valid, b_src_ready;
   logic [31:0] b_src_data;
   logic        b_in_valid, b_in_ready, b_s2p_out_valid, b_s2p_out_ready;
   logic        b_out_valid, b_out_ready;
   logic [7:0]  b_in_data, b_s2p_out_data, b_out_data;
   logic [1:0]  b_out_id;

   serial_stream_arbiter #(.NUM_SOURCES(4), .INPUT_SIZE(8), .OUTPUT_SIZE(8)) dut_b (
      .clk(clk), .rstn(rstn),
      .src_valid(b_src_valid), .src_ready(b_src_ready), .src_data(b_src_data),
      .s2p_in_valid(b_in_valid), .s2p_in_ready(b_in_ready), .s2p_in_data(b_in_data),
      .s2p_out_valid(b_s2p_out_valid), .s2p_out_ready(b_s2p_out_ready), .s2p_out_data(b_s2p_out_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_id(b_out_id)
   );

   // Deserializer models: first beat lands in the LSB; serial input stalls while a word is held.
   logic [7:0] ds_shift;
   logic [2:0] ds_cnt;
   logic       ds_v;
   assign s2p_in_ready  = !ds_v || s2p_out_ready;
   assign s2p_out_valid = ds_v;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ds_shift <= '0; ds_cnt <= '0; ds_v <= 1'b0; s2p_out_data <= '0;
      end else begin
         if (ds_v && s2p_out_ready) ds_v <= 1'b0;
         if (s2p_in_valid && s2p_in_ready) begin
            ds_shift <= {s2p_in_data, ds_shift[7:1]};
            ds_cnt   <= ds_cnt + 3'd1;
            if (ds_cnt == 3'd7) begin
               s2p_out_data <= {s2p_in_data, ds_shift[7:1]};
               ds_v         <= 1'b1;
            end
         end
      end
   end

   assign b_in_ready = !b_s2p_out_valid || b_s2p_out_ready;
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         b_s2p_out_valid <= 1'b0; b_s2p_out_data <= '0;
      end else begin
         if (b_s2p_out_valid && b_s2p_out_ready) b_s2p_out_valid <= 1'b0;
         if (b_in_valid && b_in_ready) begin
            b_s2p_out_valid <= 1'b1;
            b_s2p_out_data  <= b_in_data;
         end
      end
   end

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t       sb[$];
   exp_t       b_sb[$];
   int         out_t[$];
   logic [7:0] src_q[4][$];
   logic [7:0] b_src_q[4][$];
   int         bidx[4];
   int         pause_at[4];
   int         pause_left[4];
   bit         b_rand_rdy = 1'b0;

   function automatic exp_t mk(input int id, input logic [7:0] d);
      exp_t r;
      r.id   = 2'(id);
      r.data = d;
      return r;
   endfunction

   // Source drivers: handshakes sampled mid-cycle, next beats presented just after the edge.
   initial begin : drivers
      logic [3:0] fire, b_fire;
      logic [7:0] tmp;
      src_valid = '0; src_data = '0; b_src_valid = '0; b_src_data = '0; b_out_ready = 1'b1;
      forever begin
         @(negedge clk);
         fire   = src_valid & src_ready;
         b_fire = b_src_valid & b_src_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (fire[i] && src_q[i].size() > 0) begin
               bidx[i]++;
               if (bidx[i] == 8) begin
                  void'(src_q[i].pop_front());
                  bidx[i] = 0;
               end
            end
            if (b_fire[i] && b_src_q[i].size() > 0) void'(b_src_q[i].pop_front());
            src_valid[i] = src_q[i].size() > 0;
            if (src_valid[i] && bidx[i] == pause_at[i] && pause_left[i] > 0) begin
               src_valid[i] = 1'b0;
               pause_left[i]--;
            end
            if (src_q[i].size() > 0) begin
               tmp = src_q[i][0];
               src_data[i] = tmp[bidx[i]];
            end else begin
               src_data[i] = 1'b0;
            end
            b_src_valid[i] = b_src_q[i].size() > 0;
            b_src_data[i*8 +: 8] = (b_src_q[i].size() > 0) ? b_src_q[i][0] : 8'h00;
         end
         b_out_ready = b_rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : monitors
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL serial_unexpected_word got id=%0d data=%h required no word", out_id, out_data);
            end else begin
               e = sb.pop_front();
               out_t.push_back(cyc);
               if (out_id !== e.id || out_data !== e.data) begin
                  failures++;
                  $display("FAIL serial_word got id=%0d data=%h required id=%0d data=%h", out_id, out_data, e.id, e.data);
               end
            end
         end
         if (b_out_valid && b_out_ready) begin
            checks++;
            if (b_sb.size() == 0) begin
               failures++;
               $display("FAIL byte_unexpected_word got id=%0d data=%h required no word", b_out_id, b_out_data);
            end else begin
               e = b_sb.pop_front();
               if (b_out_id !== e.id || b_out_data !== e.data) begin
                  failures++;
                  $display("FAIL byte_word got id=%0d data=%h required id=%0d data=%h", b_out_id, b_out_data, e.id, e.data);
               end
            end
         end
      end
   end

   task automatic drain(input int maxc, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (sb.size() == 0 && b_sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #2 rstn = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (src_ready !== 4'b0) begin failures++; $display("FAIL reset_src_ready got %b required 0000", src_ready); end
      checks++; if (s2p_in_valid !== 1'b0) begin failures++; $display("FAIL reset_in_valid got %b required 0", s2p_in_valid); end
      checks++; if (out_id !== 2'd0) begin failures++; $display("FAIL reset_out_id got %0d required 0", out_id); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
      checks++; if (b_src_ready !== 4'b0) begin failures++; $display("FAIL reset_b_src_ready got %b required 0000", b_src_ready); end
      @(posedge clk);
      #1 rstn = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (src_ready !== 4'b0 || s2p_in_valid !== 1'b0) begin
         failures++; $display("FAIL idle_outputs got ready=%b in_valid=%b required 0000/0", src_ready, s2p_in_valid);
      end
   endtask

   task automatic test_single_source();
      bit ok;
      int gap;
      out_t.delete();
      src_q[2].push_back(8'hA5); src_q[2].push_back(8'h3C);
      sb.push_back(mk(2, 8'hA5)); sb.push_back(mk(2, 8'h3C));
      drain(80, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_drain got pending=%0d required 0", sb.size()); end
      gap = (out_t.size() == 2) ? out_t[1] - out_t[0] : -1;
      checks++; if (gap != 9) begin failures++; $display("FAIL single_word_spacing got %0d required 9", gap); end
   endtask

   task automatic test_all_sources();
      logic [7:0] w[4][2];
      int multi = 0;
      bit ok = 1'b0;
      for (int s = 0; s < 4; s++)
         for (int k = 0; k < 2; k++) begin
            w[s][k] = 8'($urandom);
            src_q[s].push_back(w[s][k]);
         end
      // Round-robin after source 2 finished last: 3,0,1,2 then again
      for (int j = 0; j < 8; j++) sb.push_back(mk((3 + j) % 4, w[(3 + j) % 4][j / 4]));
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if ($countones(src_ready) > 1) multi++;
         if (sb.size() == 0) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin failures++; $display("FAIL all_drain got pending=%0d required 0", sb.size()); end
      checks++; if (multi != 0) begin failures++; $display("FAIL ready_onehot got %0d multi-ready cycles required 0", multi); end
   endtask

   task automatic test_hold_grant();
      logic [7:0] w1, w0;
      int  bad = 0;
      bit  ok = 1'b0;
      w1 = 8'($urandom); w0 = 8'($urandom);
      pause_at[1] = 4; pause_left[1] = 3;
      src_q[1].push_back(w1);
      sb.push_back(mk(1, w1)); sb.push_back(mk(0, w0));
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (src_ready[1]) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin failures++; $display("FAIL hold_grant1 got no grant required src 1 granted"); end
      src_q[0].push_back(w0);
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (src_ready[0]) bad++;
         if (sb.size() < 2) break;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL hold_src0_ready got %0d cycles high required 0", bad); end
      checks++; if (pause_left[1] != 0) begin failures++; $display("FAIL hold_pause_taken got %0d left required 0", pause_left[1]); end
      pause_at[1] = -1;
      drain(80, ok);
      checks++; if (!ok) begin failures++; $display("FAIL hold_drain got pending=%0d required 0", sb.size()); end
   endtask

   task automatic test_backpressure();
      logic [7:0] p, q;
      bit seen = 1'b0;
      bit ok;
      p = 8'($urandom); q = 8'($urandom);
      @(posedge clk);
      #1 out_ready = 1'b0;
      src_q[2].push_back(p); src_q[3].push_back(q);
      sb.push_back(mk(2, p)); sb.push_back(mk(3, q));
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (out_valid) begin seen = 1'b1; break; end
      end
      checks++; if (!seen) begin failures++; $display("FAIL bp_first_word got none required valid word"); end
      repeat (12) @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== p) begin failures++; $display("FAIL bp_held_word got v=%b data=%h required 1/%h", out_valid, out_data, p); end
      checks++; if (out_id !== 2'd2) begin failures++; $display("FAIL bp_out_id got %0d required 2", out_id); end
      checks++; if (s2p_in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got %b required 0", s2p_in_ready); end
      checks++; if (src_ready !== 4'b0) begin failures++; $display("FAIL bp_src_ready got %b required 0000", src_ready); end
      checks++; if (s2p_in_valid !== 1'b1) begin failures++; $display("FAIL bp_src3_waiting got in_valid=%b required 1", s2p_in_valid); end
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain(80, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_drain got pending=%0d required 0", sb.size()); end
   endtask

   task automatic test_beats1();
      logic [7:0] w[4][3];
      bit ok;
      for (int s = 0; s < 4; s++)
         for (int k = 0; k < 3; k++) begin
            w[s][k] = 8'($urandom);
            b_src_q[s].push_back(w[s][k]);
         end
      for (int j = 0; j < 12; j++) b_sb.push_back(mk(j % 4, w[j % 4][j / 4]));
      b_rand_rdy = 1'b1;
      drain(400, ok);
      b_rand_rdy = 1'b0;
      checks++; if (!ok) begin failures++; $display("FAIL beats1_drain got pending=%0d required 0", b_sb.size()); end
   endtask

   task automatic test_reset_midword();
      logic [7:0] w0, w3;
      bit ok = 1'b0;
      w0 = 8'($urandom); w3 = 8'($urandom);
      src_q[3].push_back(8'h5A);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bidx[3] == 5) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin failures++; $display("FAIL rst_partial_beats got %0d required 5", bidx[3]); end
      rstn = 1'b0;
      src_q[3].delete();
      bidx[3] = 0;
      #1;
      checks++; if (src_ready !== 4'b0 || s2p_in_valid !== 1'b0) begin
         failures++; $display("FAIL rst_mid_outputs got ready=%b in_valid=%b required 0000/0", src_ready, s2p_in_valid);
      end
      checks++; if (out_id !== 2'd0) begin failures++; $display("FAIL rst_mid_out_id got %0d required 0", out_id); end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      src_q[0].push_back(w0); src_q[3].push_back(w3);
      sb.push_back(mk(0, w0)); sb.push_back(mk(3, w3));
      drain(80, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rst_drain got pending=%0d required 0", sb.size()); end
   endtask

   initial begin
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bidx[i] = 0; pause_at[i] = -1; pause_left[i] = 0;
      end
      test_reset();
      test_single_source();
      test_all_sources();
      test_hold_grant();
      test_backpressure();
      test_beats1();
      test_reset_midword();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
